alu_seq: RTL and testbench

Parametrised, registered successor to the combinational ripple ALU: a WIDTH-bit ALU with a 3-bit opcode, status flags, and a multi-cycle shift-add multiplier. Operands arrive over a valid/ready handshake, and results leave over a second one. It sits between the operand register file and the writeback stage, and the whole block is held off under writeback backpressure. One operation is in flight at a time.

---
 rtl/alu_seq.sv | 186 ++++++++++++++++++
 tb/tb_alu_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with status flags and a shift-add multiplier.
// Ports: clk/rst_n, in_valid/in_ready + a/b/cin/opcode in, out_valid/out_ready + result/result_hi/flags out.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int M  = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic               cout_q;
    logic               zero_q;
    logic               neg_q;
    logic               ovf_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;

    logic [WIDTH-1:0]   alu_res_d;
    logic               alu_c_d;
    logic               alu_v_d;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH-1:0]   b_inv;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_d;

    assign b_inv = ~b;

    // Single-cycle ops, evaluated straight from the input bundle.
    always_comb begin
        alu_res_d = '0;
        alu_c_d   = 1'b0;
        alu_v_d   = 1'b0;
        sum_w     = '0;
        unique case (op_e'(opcode))
            OP_ADD: begin
                sum_w     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                alu_res_d = sum_w[M:0];
                alu_c_d   = sum_w[WIDTH];
                alu_v_d   = (a[M] == b[M]) && (sum_w[M] != a[M]);
            end
            OP_SUB: begin
                // cout=1 here means no borrow
                sum_w     = {1'b0, a} + {1'b0, b_inv} + {{WIDTH{1'b0}}, 1'b1};
                alu_res_d = sum_w[M:0];
                alu_c_d   = sum_w[WIDTH];
                alu_v_d   = (a[M] == b_inv[M]) && (sum_w[M] != a[M]);
            end
            OP_AND: alu_res_d = a & b;
            OP_OR:  alu_res_d = a | b;
            OP_XOR: alu_res_d = a ^ b;
            OP_SHL: begin
                alu_res_d = {a[M-1:0], cin};
                alu_c_d   = a[M];
            end
            OP_SHR: begin
                alu_res_d = {cin, a[M:1]};
                alu_c_d   = a[0];
            end
            OP_MUL: alu_res_d = '0;
        endcase
    end

    // One shift-add step: high half accumulates the multiplicand when
    // the current multiplier LSB (low half bit 0) is set, then shift right.
    always_comb begin
        mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod_d  = {mul_sum, prod_q[M:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        if (op_e'(opcode) == OP_MUL) begin
                            mcand_q <= a;
                            prod_q  <= {{WIDTH{1'b0}}, b};
                            cnt_q   <= CW'(WIDTH - 1);
                            state_q <= BUSY;
                        end else begin
                            result_q    <= alu_res_d;
                            result_hi_q <= '0;
                            cout_q      <= alu_c_d;
                            zero_q      <= (alu_res_d == '0);
                            neg_q       <= alu_res_d[M];
                            ovf_q       <= alu_v_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    prod_q <= prod_d;
                    if (cnt_q == '0) begin
                        result_q    <= prod_d[M:0];
                        result_hi_q <= prod_d[2*WIDTH-1:WIDTH];
                        cout_q      <= |prod_d[2*WIDTH-1:WIDTH];
                        zero_q      <= (prod_d[M:0] == '0);
                        neg_q       <= prod_d[M];
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector bench for alu_seq (WIDTH=8).
// Table-driven ops plus backpressure and mid-MUL reset sequences.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic [2:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result, result_hi;
    logic         cout, zero, neg, ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .cout      (cout),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
    );

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Issue one bundle, wait for the result, check latency and outputs,
    // then complete the handshake and check in_ready comes back.
    task automatic run_op(input vec_t v);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = v.op;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        lat = 0;
        while (!in_ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({v.name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        chk({v.name, ".lat"}, lat, (v.op == 3'b111) ? W + 1 : 1);
        chk({v.name, ".res"}, {24'd0, result}, {24'd0, v.res});
        chk({v.name, ".hi"}, {24'd0, result_hi}, {24'd0, v.hi});
        chk({v.name, ".flags"}, {28'd0, cout, zero, neg, ovf},
            {28'd0, v.c, v.z, v.n, v.v});
        @(negedge clk);
        chk({v.name, ".rdy_back"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        vec_t t;
        int   k;
        logic [W-1:0] held;

        vecs[0]  = '{"add_ff_01", 3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1, 1, 0, 0};
        vecs[1]  = '{"sub_80_01", 3'b001, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 1, 0, 0, 1};
        vecs[2]  = '{"sub_01_02", 3'b001, 8'h01, 8'h02, 1'b1, 8'hFF, 8'h00, 0, 0, 1, 0};
        vecs[3]  = '{"shl_81",    3'b101, 8'h81, 8'h00, 1'b1, 8'h03, 8'h00, 1, 0, 0, 0};
        vecs[4]  = '{"shr_01",    3'b110, 8'h01, 8'h00, 1'b1, 8'h80, 8'h00, 1, 0, 1, 0};
        vecs[5]  = '{"mul_ff_ff", 3'b111, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1, 0, 0, 0};
        vecs[6]  = '{"mul_0f_11", 3'b111, 8'h0F, 8'h11, 1'b0, 8'hFF, 8'h00, 0, 0, 1, 0};
        vecs[7]  = '{"and",       3'b010, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 0, 0, 0, 0};
        vecs[8]  = '{"or",        3'b011, 8'h0F, 8'hF0, 1'b0, 8'hFF, 8'h00, 0, 0, 1, 0};
        vecs[9]  = '{"xor",       3'b100, 8'hAA, 8'hAA, 1'b0, 8'h00, 8'h00, 0, 1, 0, 0};
        vecs[10] = '{"add_ovf",   3'b000, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 0, 0, 1, 1};
        vecs[11] = '{"add_cin",   3'b000, 8'h10, 8'h20, 1'b1, 8'h31, 8'h00, 0, 0, 0, 0};
        vecs[12] = '{"mul_zero",  3'b111, 8'h00, 8'h55, 1'b0, 8'h00, 8'h00, 0, 1, 0, 0};
        vecs[13] = '{"mul_10_10", 3'b111, 8'h10, 8'h10, 1'b0, 8'h00, 8'h01, 1, 1, 0, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; opcode = '0;
        #12;
        chk("rst.outs", {22'd0, out_valid, result, cout, zero, neg, ovf}, 32'd0);
        chk("rst.hi", {24'd0, result_hi}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 14; i++) run_op(vecs[i]);

        // Backpressure: result held, new bundle ignored, in_ready after handshake.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; opcode = 3'b000; a = 8'h02; b = 8'h03; cin = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp.valid", {31'd0, out_valid}, 32'd1);
        held = result;
        chk("bp.res", {24'd0, held}, 32'h05);
        in_valid = 1'b1; opcode = 3'b001; a = 8'h10; b = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.hold", {22'd0, in_ready, out_valid, result},
                {22'd0, 1'b0, 1'b1, held});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.release", {30'd0, in_ready, out_valid}, 32'd2);
        chk("bp.res_after", {24'd0, result}, 32'h05);

        // Reset three cycles into a MUL.
        @(negedge clk);
        in_valid = 1'b1; opcode = 3'b111; a = 8'hFF; b = 8'hFF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst.outs", {22'd0, out_valid, result, cout, zero, neg, ovf}, 32'd0);
        chk("mrst.hi", {24'd0, result_hi}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst.in_ready", {31'd0, in_ready}, 32'd1);
        k = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        chk("mrst.no_stray", k, 0);
        t = '{"add_after_rst", 3'b000, 8'h02, 8'h03, 1'b0, 8'h05, 8'h00, 0, 0, 0, 0};
        run_op(t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
